mem_op_sequencer: RTL and testbench

MEM_OP_SEQUENCER -- requirements
Module: mem_op_sequencer

---
 rtl/mem_op_sequencer_pkg.sv | 34 +++
 rtl/mem_op_sequencer_imm_adder.sv | 22 ++
 rtl/mem_op_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_mem_op_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_op_sequencer_pkg.sv
// mem_op_sequencer_pkg
// Shared controller header for the memory-operand instruction sequencer.
// It holds the operation class codes from the memory decoder, the
// sequencer FSM state encoding, the immediate-fetch timeout value and a
// small helper that classifies an operation code.
package mem_op_sequencer_pkg;

    // Operation class codes carried on state_control
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    // One-hot write enable for register A, the fixed target of an add
    localparam logic [3:0] REG_A_ONEHOT = 4'b0001;

    // Wait-counter value at which an outstanding immediate fetch gives up
    localparam logic [3:0] FETCH_TIMEOUT = 4'd15;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_DONE  = 2'b11
    } seq_state_e;

    // Only load and add need an immediate byte; the other two codes are
    // unsupported and go straight to DONE with the illegal flag raised.
    function automatic logic needsImmediate(input logic [1:0] op);
        return (op != OP_NOP) && (op != OP_RSVD);
    endfunction

endpackage

// File: rtl/mem_op_sequencer_imm_adder.sv
// imm_adder
// Adds a register-bank byte to the fetched immediate and produces the
// flags an add instruction records.
// Ports:
//   a     in  8  register-bank operand
//   b     in  8  immediate operand
//   sum   out 8  (a + b) modulo 256
//   carry out 1  bit 8 of the 9-bit sum
//   zero  out 1  wrapped sum equals zero
module imm_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       carry,
    output logic       zero
);

    // Widen both operands so the carry falls out as the ninth bit
    assign {carry, sum} = {1'b0, a} + {1'b0, b};
    assign zero         = (sum == 8'd0);

endmodule

// File: rtl/mem_op_sequencer.sv
// mem_op_sequencer
// Sequences one decoded memory-operand instruction: it latches the decoded
// fields, fetches an immediate byte from program memory (with a bounded
// wait), then either loads the byte into a register or adds it to a bank
// register into A, and finally signals completion.
// Ports:
//   clk                  in  1  rising-edge clock
//   rst                  in  1  asynchronous active-high reset
//   start                in  1  decoded instruction valid pulse
//   state_control        in  2  operation class
//   destination_reg_flag in  4  one-hot load target (A=bit0 .. D=bit3)
//   bank_out_sel         in  2  register-bank read select
//   mem_data             in  8  immediate byte from program memory
//   mem_ready            in  1  mem_data valid this cycle
//   bank_data            in  8  register-bank read data
//   mem_rd               out 1  immediate read request (FETCH)
//   pc_inc               out 1  program-counter increment strobe
//   bank_sel             out 2  latched bank select
//   reg_we               out 4  one-hot register write enable (EXEC only)
//   reg_wdata            out 8  register write data (EXEC only)
//   carry                out 1  carry flag from the last add
//   zero                 out 1  zero flag from the last add
//   busy                 out 1  sequencer not idle
//   done                 out 1  instruction complete pulse
//   fetch_err            out 1  immediate fetch timeout pulse
//   illegal              out 1  unsupported operation pulse
module mem_op_sequencer
    import mem_op_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] state_control,
    input  logic [3:0] destination_reg_flag,
    input  logic [1:0] bank_out_sel,
    input  logic [7:0] mem_data,
    input  logic       mem_ready,
    input  logic [7:0] bank_data,
    output logic       mem_rd,
    output logic       pc_inc,
    output logic [1:0] bank_sel,
    output logic [3:0] reg_we,
    output logic [7:0] reg_wdata,
    output logic       carry,
    output logic       zero,
    output logic       busy,
    output logic       done,
    output logic       fetch_err,
    output logic       illegal
);

    seq_state_e state_q, state_d;

    logic [1:0] opCode_q;
    logic [3:0] destFlag_q;
    logic [1:0] bankSel_q;
    logic [7:0] imm_q;
    logic [3:0] waitCnt_q;
    logic       carry_q;
    logic       zero_q;

    logic       latchFields;
    logic       captureImm;
    logic       clearWait;
    logic       incWait;
    logic       updateFlags;

    logic [7:0] addSum;
    logic       addCarry;
    logic       addZero;

    imm_adder u_imm_adder (
        .a     (bank_data),
        .b     (imm_q),
        .sum   (addSum),
        .carry (addCarry),
        .zero  (addZero)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode. pc_inc and fetch_err are Mealy on
    // mem_ready so the PC advances in the same cycle the byte is consumed.
    always_comb begin
        state_d     = state_q;
        mem_rd      = 1'b0;
        pc_inc      = 1'b0;
        reg_we      = 4'b0000;
        reg_wdata   = 8'h00;
        done        = 1'b0;
        fetch_err   = 1'b0;
        illegal     = 1'b0;
        latchFields = 1'b0;
        captureImm  = 1'b0;
        clearWait   = 1'b0;
        incWait     = 1'b0;
        updateFlags = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    latchFields = 1'b1;
                    clearWait   = 1'b1;
                    state_d     = needsImmediate(state_control) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                mem_rd = 1'b1;
                pc_inc = mem_ready;
                if (mem_ready) begin
                    captureImm = 1'b1;
                    state_d    = ST_EXEC;
                end else if (waitCnt_q == FETCH_TIMEOUT) begin
                    fetch_err = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    incWait = 1'b1;
                end
            end
            ST_EXEC: begin
                // Only load and add ever reach EXEC
                if (opCode_q == OP_ADD) begin
                    reg_we      = REG_A_ONEHOT;
                    reg_wdata   = addSum;
                    updateFlags = 1'b1;
                end else begin
                    reg_we    = destFlag_q;
                    reg_wdata = imm_q;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                illegal = !needsImmediate(opCode_q);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latched instruction fields, immediate, wait counter and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opCode_q   <= OP_NOP;
            destFlag_q <= 4'b0000;
            bankSel_q  <= 2'b00;
            imm_q      <= 8'h00;
            waitCnt_q  <= 4'd0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            if (latchFields) begin
                opCode_q   <= state_control;
                destFlag_q <= destination_reg_flag;
                bankSel_q  <= bank_out_sel;
            end
            if (clearWait) begin
                waitCnt_q <= 4'd0;
            end else if (incWait) begin
                waitCnt_q <= waitCnt_q + 4'd1;
            end
            if (captureImm) begin
                imm_q <= mem_data;
            end
            if (updateFlags) begin
                carry_q <= addCarry;
                zero_q  <= addZero;
            end
        end
    end

    assign bank_sel = bankSel_q;
    assign carry    = carry_q;
    assign zero     = zero_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_op_sequencer.sv
// tb_mem_op_sequencer
// Drives instructions into mem_op_sequencer and compares what it observes
// against a cycle-count model of the instruction timeline.
module tb_mem_op_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] state_control;
    logic [3:0] destination_reg_flag;
    logic [1:0] bank_out_sel;
    logic [7:0] mem_data;
    logic       mem_ready;
    logic [7:0] bank_data;
    logic       mem_rd;
    logic       pc_inc;
    logic [1:0] bank_sel;
    logic [3:0] reg_we;
    logic [7:0] reg_wdata;
    logic       carry;
    logic       zero;
    logic       busy;
    logic       done;
    logic       fetch_err;
    logic       illegal;

    int total = 0;
    int bad   = 0;

    // Flags the model expects the DUT to hold
    logic mCarry = 1'b0;
    logic mZero  = 1'b0;

    // Observations of one instruction
    int         oDone, oWeCyc, oPc, oRd, oErr, oWeCnt, oStray;
    logic [3:0] oWe;
    logic [7:0] oWd;
    logic       oIll, oBusyAfter;

    typedef struct {
        int         doneCyc;
        int         weCyc;
        logic [3:0] weVal;
        logic [7:0] wd;
        int         pcCnt;
        int         rdCnt;
        int         errCyc;
        logic       ill;
        logic       carry;
        logic       zero;
    } exp_t;

    mem_op_sequencer dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .state_control        (state_control),
        .destination_reg_flag (destination_reg_flag),
        .bank_out_sel         (bank_out_sel),
        .mem_data             (mem_data),
        .mem_ready            (mem_ready),
        .bank_data            (bank_data),
        .mem_rd               (mem_rd),
        .pc_inc               (pc_inc),
        .bank_sel             (bank_sel),
        .reg_we               (reg_we),
        .reg_wdata            (reg_wdata),
        .carry                (carry),
        .zero                 (zero),
        .busy                 (busy),
        .done                 (done),
        .fetch_err            (fetch_err),
        .illegal              (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction timeline model: cycle 0 is the start cycle, the fetch
    // occupies cycles 1..waits+1, the write follows, then done. A fetch
    // tolerates at most 15 wait cycles; the 16th fetch cycle times out.
    function automatic exp_t model(input logic [1:0] op, input logic [3:0] dest,
                                   input logic [7:0] imm, input logic [7:0] bank,
                                   input int waits, input logic cIn, input logic zIn);
        exp_t e;
        int   s;
        e = '{doneCyc: -1, weCyc: -1, weVal: 4'd0, wd: 8'd0, pcCnt: 0, rdCnt: 0,
              errCyc: -1, ill: 1'b0, carry: cIn, zero: zIn};
        if (op == 2'b00 || op == 2'b11) begin
            e.doneCyc = 1;
            e.ill     = 1'b1;
        end else if (waits > 15) begin
            e.rdCnt  = 16;
            e.errCyc = 16;
        end else begin
            e.pcCnt   = 1;
            e.rdCnt   = waits + 1;
            e.weCyc   = waits + 2;
            e.doneCyc = waits + 3;
            if (op == 2'b01) begin
                e.weVal = dest;
                e.wd    = imm;
            end else begin
                s       = int'(bank) + int'(imm);
                e.weVal = 4'b0001;
                e.wd    = 8'(s % 256);
                e.carry = (s > 255);
                e.zero  = ((s % 256) == 0);
            end
        end
        return e;
    endfunction

    // Issues one instruction and records what the DUT does, bounded to 40
    // cycles. intrCyc>0 drives a competing start in that cycle.
    task automatic runOp(input logic [1:0] op, input logic [3:0] dest, input logic [1:0] sel,
                         input logic [7:0] imm, input logic [7:0] bank, input int waits,
                         input int intrCyc);
        oDone = -1; oWeCyc = -1; oWe = 4'd0; oWd = 8'd0; oPc = 0; oRd = 0;
        oErr = -1; oIll = 1'b0; oWeCnt = 0; oStray = 0; oBusyAfter = 1'b1;
        state_control        = op;
        destination_reg_flag = dest;
        bank_out_sel         = sel;
        bank_data            = bank;
        mem_data             = 8'($urandom);
        mem_ready            = 1'b0;
        start                = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            mem_ready = (cyc == waits + 1);
            mem_data  = mem_ready ? imm : 8'($urandom);
            if (cyc == intrCyc) begin
                start                = 1'b1;
                state_control        = 2'b11;
                destination_reg_flag = ~dest;
                bank_out_sel         = ~sel;
            end
            #1;
            if (reg_we != 4'd0) begin
                oWeCnt++;
                if (oWeCyc < 0) begin
                    oWeCyc = cyc; oWe = reg_we; oWd = reg_wdata;
                end
            end else if (reg_wdata != 8'd0) begin
                oStray++;
            end
            if (illegal && !done) oStray++;
            if (pc_inc) oPc++;
            if (mem_rd) oRd++;
            if (done) begin
                oDone = cyc; oIll = illegal;
            end
            if (fetch_err) oErr = cyc;
            @(posedge clk); #1;
            if (cyc == intrCyc) begin
                start                = 1'b0;
                state_control        = op;
                destination_reg_flag = dest;
                bank_out_sel         = sel;
            end
            if (oDone >= 0 || oErr >= 0) begin
                oBusyAfter = busy;
                break;
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; state_control = 2'b01; destination_reg_flag = 4'b1111;
        bank_out_sel = 2'b11; mem_data = 8'hFF; mem_ready = 1'b1; bank_data = 8'hFF;
        #2;
        total++;
        if ({mem_rd, pc_inc, bank_sel, reg_we, reg_wdata, carry, zero, busy, done, fetch_err, illegal} !== 22'd0) begin
            bad++; $display("[TB] FAIL reset_outputs: got busy=%b reg_we=%b bank_sel=%b, need all zero", busy, reg_we, bank_sel);
        end
        @(posedge clk); #1;
        total++;
        if ({mem_rd, busy, done, reg_we} !== 7'd0) begin
            bad++; $display("[TB] FAIL reset_hold: got mem_rd=%b busy=%b done=%b reg_we=%b, need 0", mem_rd, busy, done, reg_we);
        end
        start = 1'b0; mem_ready = 1'b0; rst = 1'b0;
    endtask

    task automatic test_add();
        runOp(2'b10, 4'b1000, 2'b01, 8'h20, 8'hF0, 0, 0);
        total++;
        if (oWe !== 4'b0001 || oWd !== 8'h10 || oWeCyc != 2 || oDone != 3) begin
            bad++; $display("[TB] FAIL add_overflow: got we=%b wd=%h at %0d done %0d, need 0001 10 at 2 done 3", oWe, oWd, oWeCyc, oDone);
        end
        total++;
        if (carry !== 1'b1 || zero !== 1'b0 || bank_sel !== 2'b01) begin
            bad++; $display("[TB] FAIL add_flags: got c=%b z=%b sel=%b, need 1 0 01", carry, zero, bank_sel);
        end
        runOp(2'b10, 4'b0100, 2'b01, 8'h10, 8'hF0, 0, 0);
        total++;
        if (oWd !== 8'h00 || carry !== 1'b1 || zero !== 1'b1) begin
            bad++; $display("[TB] FAIL add_zero: got wd=%h c=%b z=%b, need 00 1 1", oWd, carry, zero);
        end
        mCarry = 1'b1; mZero = 1'b1;
    endtask

    task automatic test_load();
        runOp(2'b01, 4'b0100, 2'b10, 8'h5A, 8'h33, 0, 0);
        total++;
        if (oWe !== 4'b0100 || oWd !== 8'h5A || oWeCyc != 2 || oDone != 3 || oWeCnt != 1) begin
            bad++; $display("[TB] FAIL load_basic: got we=%b wd=%h at %0d done %0d n=%0d, need 0100 5a at 2 done 3 n=1", oWe, oWd, oWeCyc, oDone, oWeCnt);
        end
        total++;
        if (carry !== mCarry || zero !== mZero || oStray != 0 || oBusyAfter !== 1'b0) begin
            bad++; $display("[TB] FAIL load_flags: got c=%b z=%b stray=%0d busy=%b, need %b %b 0 0", carry, zero, oStray, oBusyAfter, mCarry, mZero);
        end
    endtask

    task automatic test_wait();
        runOp(2'b01, 4'b0010, 2'b00, 8'hC3, 8'h00, 3, 0);
        total++;
        if (oPc != 1 || oDone != 6 || oRd != 4 || oWd !== 8'hC3) begin
            bad++; $display("[TB] FAIL wait_3: got pc=%0d done=%0d rd=%0d wd=%h, need 1 6 4 c3", oPc, oDone, oRd, oWd);
        end
        runOp(2'b01, 4'b1000, 2'b00, 8'h81, 8'h00, 15, 0);
        total++;
        if (oErr != -1 || oDone != 18 || oWe !== 4'b1000 || oWd !== 8'h81) begin
            bad++; $display("[TB] FAIL wait_15: got err=%0d done=%0d we=%b wd=%h, need -1 18 1000 81", oErr, oDone, oWe, oWd);
        end
    endtask

    task automatic test_timeout();
        runOp(2'b10, 4'b0001, 2'b11, 8'h01, 8'hFF, 99, 0);
        total++;
        if (oErr != 16 || oDone != -1 || oWeCnt != 0 || oBusyAfter !== 1'b0 || oRd != 16 || oPc != 0) begin
            bad++; $display("[TB] FAIL timeout: got err=%0d done=%0d we=%0d busy=%b rd=%0d pc=%0d, need 16 -1 0 0 16 0", oErr, oDone, oWeCnt, oBusyAfter, oRd, oPc);
        end
        total++;
        if (carry !== mCarry || zero !== mZero) begin
            bad++; $display("[TB] FAIL timeout_flags: got c=%b z=%b, need %b %b", carry, zero, mCarry, mZero);
        end
    endtask

    task automatic test_illegal();
        logic [1:0] codes [2] = '{2'b11, 2'b00};
        foreach (codes[i]) begin
            runOp(codes[i], 4'b0001, 2'b10, 8'h44, 8'h00, 0, 0);
            total++;
            if (oDone != 1 || oIll !== 1'b1 || oRd != 0 || oWeCnt != 0 || oStray != 0) begin
                bad++; $display("[TB] FAIL illegal_%b: got done=%0d ill=%b rd=%0d we=%0d stray=%0d, need 1 1 0 0 0", codes[i], oDone, oIll, oRd, oWeCnt, oStray);
            end
        end
    endtask

    task automatic test_busy_start();
        runOp(2'b01, 4'b0010, 2'b10, 8'h3C, 8'h00, 3, 2);
        total++;
        if (oWe !== 4'b0010 || oWd !== 8'h3C || oDone != 6 || bank_sel !== 2'b10 || oIll !== 1'b0 || oBusyAfter !== 1'b0) begin
            bad++; $display("[TB] FAIL busy_start: got we=%b wd=%h done=%0d sel=%b ill=%b busy=%b, need 0010 3c 6 10 0 0", oWe, oWd, oDone, bank_sel, oIll, oBusyAfter);
        end
    endtask

    task automatic test_reset_mid_op();
        int late = 0;
        state_control = 2'b10; destination_reg_flag = 4'b1000; bank_out_sel = 2'b11;
        bank_data = 8'h01; mem_data = 8'h02; mem_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        total++;
        if (reg_we !== 4'b0001 || reg_wdata !== 8'h03) begin
            bad++; $display("[TB] FAIL mid_exec: got we=%b wd=%h, need 0001 03", reg_we, reg_wdata);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({mem_rd, pc_inc, bank_sel, reg_we, reg_wdata, carry, zero, busy, done, fetch_err, illegal} !== 22'd0) begin
            bad++; $display("[TB] FAIL reset_in_exec: got we=%b busy=%b sel=%b c=%b z=%b, need all zero", reg_we, busy, bank_sel, carry, zero);
        end
        mem_ready = 1'b0;
        mCarry = 1'b0; mZero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (reg_we != 4'd0 || done || fetch_err || busy) late++;
            @(posedge clk); #1;
        end
        total++;
        if (late != 0) begin
            bad++; $display("[TB] FAIL reset_abort: got %0d active cycles after release, need 0", late);
        end
        runOp(2'b01, 4'b0001, 2'b01, 8'h77, 8'h00, 0, 0);
        total++;
        if (oWe !== 4'b0001 || oWd !== 8'h77 || oDone != 3 || carry !== 1'b0 || zero !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_recover: got we=%b wd=%h done=%0d c=%b z=%b, need 0001 77 3 0 0", oWe, oWd, oDone, carry, zero);
        end
    endtask

    task automatic test_random();
        exp_t       e;
        logic [1:0] op, sel;
        logic [3:0] dest;
        logic [7:0] imm, bank;
        int         waits;
        for (int n = 0; n < 30; n++) begin
            op    = 2'($urandom_range(0, 3));
            dest  = 4'b0001 << $urandom_range(0, 3);
            sel   = 2'($urandom);
            imm   = 8'($urandom);
            bank  = 8'($urandom);
            waits = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
            e = model(op, dest, imm, bank, waits, mCarry, mZero);
            runOp(op, dest, sel, imm, bank, waits, 0);
            mCarry = e.carry; mZero = e.zero;
            total++;
            if (oDone != e.doneCyc || oErr != e.errCyc || oWeCyc != e.weCyc || oWe !== e.weVal || oWd !== e.wd) begin
                bad++; $display("[TB] FAIL rand_%0d timeline: got done=%0d err=%0d we=%b@%0d wd=%h, need %0d %0d %b@%0d %h",
                                n, oDone, oErr, oWe, oWeCyc, oWd, e.doneCyc, e.errCyc, e.weVal, e.weCyc, e.wd);
            end
            total++;
            if (carry !== e.carry || zero !== e.zero || bank_sel !== sel || oPc != e.pcCnt || oRd != e.rdCnt || oIll !== e.ill || oStray != 0) begin
                bad++; $display("[TB] FAIL rand_%0d state: got c=%b z=%b sel=%b pc=%0d rd=%0d ill=%b, need %b %b %b %0d %0d %b",
                                n, carry, zero, bank_sel, oPc, oRd, oIll, e.carry, e.zero, sel, e.pcCnt, e.rdCnt, e.ill);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load();
        test_wait();
        test_timeout();
        test_illegal();
        test_busy_start();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
